mem_access_stage: RTL and testbench

- MEM stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Performs load/store accesses to data memory over a req/ack handshake with variable latency.
- Stalls the front of the pipeline while an access is outstanding.
- Drives the registered MEM/WB stage outputs, including a bubble on stall and on error, plus error flags.

---
 rtl/mem_access_stage.sv | 146 ++++++++++++++
 tb/tb_mem_access_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: issues data-memory requests over a
// req/ack handshake, stalls the front end while busy, and drives the MEM/WB register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_RegWrite,
    input  logic        wb_MemToReg,
    input  logic        mem_MemRead,
    input  logic        mem_MemWrite,
    input  logic [31:0] AluResult,
    input  logic [31:0] MuxForwardB,
    input  logic [4:0]  MuxRegDst,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_RegWrite_out,
    output logic        wb_MemToReg_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] AluResult_out,
    output logic [4:0]  MuxRegDst_out,
    output logic        misalign_out,
    output logic        bus_err_out
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        access_s, err_mis_s, good_s;
    logic        req_s, we_s;
    logic [31:0] addr_s, wdata_s;
    logic        regwrite_s, memtoreg_s, mis_s, berr_s;
    logic [31:0] rdata_s, alu_s;
    logic [4:0]  dst_s;

    // Classify the instruction sitting in EX/MEM.
    always_comb begin
        access_s  = mem_MemRead | mem_MemWrite;
        err_mis_s = access_s & ((AluResult[1:0] != 2'b00) | (mem_MemRead & mem_MemWrite));
        good_s    = access_s & ~err_mis_s;
    end

    // Next-state, stall and next MEM/WB / request values; MEM/WB defaults to a bubble.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        stall      = 1'b0;
        req_s      = dmem_req;
        we_s       = dmem_we;
        addr_s     = dmem_addr;
        wdata_s    = dmem_wdata;
        regwrite_s = 1'b0;
        memtoreg_s = 1'b0;
        mis_s      = 1'b0;
        berr_s     = 1'b0;
        rdata_s    = ReadData_out;
        alu_s      = AluResult_out;
        dst_s      = MuxRegDst_out;
        case (state_r)
            IDLE: begin
                if (good_s) begin
                    stall   = 1'b1;
                    req_s   = 1'b1;
                    we_s    = mem_MemWrite;
                    addr_s  = {AluResult[31:2], 2'b00};
                    wdata_s = MuxForwardB;
                    cnt_s   = 8'd0;
                    state_s = BUSY;
                end else if (err_mis_s) begin
                    mis_s = 1'b1;
                end else begin
                    regwrite_s = wb_RegWrite;
                    memtoreg_s = wb_MemToReg;
                    rdata_s    = 32'd0;
                    alu_s      = AluResult;
                    dst_s      = MuxRegDst;
                end
            end
            BUSY: begin
                // An ack in the timeout cycle takes priority over the abort.
                if (dmem_ack) begin
                    req_s      = 1'b0;
                    state_s    = IDLE;
                    regwrite_s = wb_RegWrite;
                    memtoreg_s = wb_MemToReg;
                    rdata_s    = mem_MemRead ? dmem_rdata : 32'd0;
                    alu_s      = AluResult;
                    dst_s      = MuxRegDst;
                end else if (cnt_r == CNT_LAST) begin
                    req_s   = 1'b0;
                    state_s = IDLE;
                    berr_s  = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_s = cnt_r + 8'd1;
                end
            end
            default: begin
                req_s   = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State, counter, request and MEM/WB registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= IDLE;
            cnt_r           <= 8'd0;
            dmem_req        <= 1'b0;
            dmem_we         <= 1'b0;
            dmem_addr       <= 32'd0;
            dmem_wdata      <= 32'd0;
            wb_RegWrite_out <= 1'b0;
            wb_MemToReg_out <= 1'b0;
            ReadData_out    <= 32'd0;
            AluResult_out   <= 32'd0;
            MuxRegDst_out   <= 5'd0;
            misalign_out    <= 1'b0;
            bus_err_out     <= 1'b0;
        end else begin
            state_r         <= state_s;
            cnt_r           <= cnt_s;
            dmem_req        <= req_s;
            dmem_we         <= we_s;
            dmem_addr       <= addr_s;
            dmem_wdata      <= wdata_s;
            wb_RegWrite_out <= regwrite_s;
            wb_MemToReg_out <= memtoreg_s;
            ReadData_out    <= rdata_s;
            AluResult_out   <= alu_s;
            MuxRegDst_out   <= dst_s;
            misalign_out    <= mis_s;
            bus_err_out     <= berr_s;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; the bench plays the role of
// both the EX/MEM register and the data memory.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_RegWrite = 1'b0, wb_MemToReg = 1'b0;
    logic        mem_MemRead = 1'b0, mem_MemWrite = 1'b0;
    logic [31:0] AluResult = 32'd0, MuxForwardB = 32'd0;
    logic [4:0]  MuxRegDst = 5'd0;
    logic        stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_ack = 1'b0;
    logic        wb_RegWrite_out, wb_MemToReg_out;
    logic [31:0] ReadData_out, AluResult_out;
    logic [4:0]  MuxRegDst_out;
    logic        misalign_out, bus_err_out;

    int n_checks = 0;
    int n_pass   = 0;
    int stall_cnt;
    int all_stall;

    mem_access_stage #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .AluResult(AluResult), .MuxForwardB(MuxForwardB), .MuxRegDst(MuxRegDst),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_RegWrite_out(wb_RegWrite_out), .wb_MemToReg_out(wb_MemToReg_out),
        .ReadData_out(ReadData_out), .AluResult_out(AluResult_out),
        .MuxRegDst_out(MuxRegDst_out), .misalign_out(misalign_out),
        .bus_err_out(bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_in(input logic rw, input logic m2r, input logic rd, input logic wr,
                          input logic [31:0] alu, input logic [31:0] fb, input logic [4:0] dst);
        wb_RegWrite  = rw;
        wb_MemToReg  = m2r;
        mem_MemRead  = rd;
        mem_MemWrite = wr;
        AluResult    = alu;
        MuxForwardB  = fb;
        MuxRegDst    = dst;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_req", dmem_req, 32'd0);
        chk("rst_regwrite", wb_RegWrite_out, 32'd0);
        chk("rst_alu", AluResult_out, 32'd0);
        #4 rst_n = 1'b1;

        // ALU op passes straight through
        cyc();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 5'd5);
        #1 chk("alu_stall", stall, 32'd0);
        cyc();
        chk("alu_regwrite", wb_RegWrite_out, 32'd1);
        chk("alu_result", AluResult_out, 32'h0000_0010);
        chk("alu_dst", MuxRegDst_out, 32'd5);
        chk("alu_rdata", ReadData_out, 32'd0);

        // Load 0x104, ack in the third stall-free-pending cycle
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'd0, 5'd7);
        #1 chk("ld_stall0", stall, 32'd1);
        cyc();
        chk("ld_req", dmem_req, 32'd1);
        chk("ld_addr", dmem_addr, 32'h0000_0104);
        chk("ld_we", dmem_we, 32'd0);
        chk("ld_bubble0", wb_RegWrite_out, 32'd0);
        chk("ld_stall1", stall, 32'd1);
        cyc();
        chk("ld_stall2", stall, 32'd1);
        chk("ld_bubble1", wb_RegWrite_out, 32'd0);
        cyc();
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("ld_stall_ack", stall, 32'd0);
        cyc();
        dmem_ack = 1'b0;
        chk("ld_req_drop", dmem_req, 32'd0);
        chk("ld_rdata", ReadData_out, 32'hDEAD_BEEF);
        chk("ld_memtoreg", wb_MemToReg_out, 32'd1);
        chk("ld_regwrite", wb_RegWrite_out, 32'd1);
        chk("ld_dst", MuxRegDst_out, 32'd7);

        // Store with immediate ack
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 5'd0);
        #1 chk("st_stall0", stall, 32'd1);
        cyc();
        chk("st_req", dmem_req, 32'd1);
        chk("st_we", dmem_we, 32'd1);
        chk("st_wdata", dmem_wdata, 32'h1234_5678);
        chk("st_addr", dmem_addr, 32'h0000_0200);
        dmem_ack = 1'b1;
        #1 chk("st_stall_ack", stall, 32'd0);
        cyc();
        dmem_ack = 1'b0;
        chk("st_req_drop", dmem_req, 32'd0);
        chk("st_rdata", ReadData_out, 32'd0);
        chk("st_alu", AluResult_out, 32'h0000_0200);

        // Misaligned load
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0103, 32'd0, 5'd9);
        #1 chk("mis_stall", stall, 32'd0);
        cyc();
        chk("mis_req", dmem_req, 32'd0);
        chk("mis_flag", misalign_out, 32'd1);
        chk("mis_regwrite", wb_RegWrite_out, 32'd0);
        // Read and write together is also a misalign error
        set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'd0, 5'd9);
        #1 chk("rw_stall", stall, 32'd0);
        cyc();
        chk("rw_req", dmem_req, 32'd0);
        chk("rw_flag", misalign_out, 32'd1);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        cyc();
        chk("mis_clear", misalign_out, 32'd0);

        // Timeout: no ack ever
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'd0, 5'd3);
        #1;
        stall_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (stall !== 1'b1) break;
            stall_cnt++;
            cyc();
        end
        chk("to_stall_cycles", stall_cnt, 32'd16);
        cyc();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        chk("to_req_drop", dmem_req, 32'd0);
        chk("to_bus_err", bus_err_out, 32'd1);
        chk("to_regwrite", wb_RegWrite_out, 32'd0);
        cyc();
        chk("to_bus_err_clear", bus_err_out, 32'd0);

        // Ack in the final (timeout) cycle wins
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'd0, 5'd4);
        cyc();
        all_stall = 1;
        for (int i = 0; i < 15; i++) begin
            if (stall !== 1'b1) all_stall = 0;
            cyc();
        end
        chk("late_stall_held", all_stall, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        #1 chk("late_stall_ack", stall, 32'd0);
        cyc();
        dmem_ack = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        chk("late_bus_err", bus_err_out, 32'd0);
        chk("late_rdata", ReadData_out, 32'hCAFE_F00D);
        chk("late_regwrite", wb_RegWrite_out, 32'd1);
        chk("late_req_drop", dmem_req, 32'd0);

        // Reset while BUSY
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0500, 32'd0, 5'd6);
        cyc();
        chk("rb_req_up", dmem_req, 32'd1);
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        #1;
        chk("rb_req", dmem_req, 32'd0);
        chk("rb_addr", dmem_addr, 32'd0);
        chk("rb_alu", AluResult_out, 32'd0);
        chk("rb_rdata", ReadData_out, 32'd0);
        chk("rb_dst", MuxRegDst_out, 32'd0);
        #3 rst_n = 1'b1;
        dmem_ack = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        #1 chk("rb_stall", stall, 32'd0);
        cyc();
        dmem_ack = 1'b0;
        chk("rb_late_req", dmem_req, 32'd0);
        chk("rb_late_rdata", ReadData_out, 32'd0);
        chk("rb_late_regwrite", wb_RegWrite_out, 32'd0);
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0600, 32'd0, 5'd2);
        #1 chk("rb_idle_stall", stall, 32'd1);
        cyc();
        chk("rb_new_req", dmem_req, 32'd1);
        chk("rb_new_addr", dmem_addr, 32'h0000_0600);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
